// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
// Requester indices double as bit positions in the request/grant vectors.
package mips32_mem_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REQ_LD = 0;
    localparam int REQ_D  = 1;
    localparam int REQ_IF = 2;

endpackage

// File: rtl/mem_arb_prio.sv
// Three-way fixed-priority select: loader > data > fetch, or loader > fetch > data when promote_if is set.
// Latency: combinational. Backpressure: losers see no grant and must hold their request.
module mem_arb_prio
    import mips32_mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic       promote_if,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[REQ_LD]) begin
            gnt[REQ_LD] = 1'b1;
        end else if (promote_if && req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end else if (req[REQ_D]) begin
            gnt[REQ_D] = 1'b1;
        end else if (req[REQ_IF]) begin
            gnt[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch, load/store and loader; holds the CPU in BOOT until loaded.
// Latency: zero-cycle grant, read data one cycle after grant. Backpressure: denied requesters hold req and payload.
module mem_port_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int             AW         = AW_DEF,
    parameter int             DW         = DW_DEF,
    parameter int             STARVE_MAX = 4,
    parameter logic [AW-1:0]  PROT_TOP   = 10'd255
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_done,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,

    output logic          cpu_hold,
    output logic          prot_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  starve_q;
    logic        prot_err_q;
    logic        rd_pend_q;
    logic [1:0]  rd_owner_q, rd_owner_d;

    logic [2:0]  req_vec, gnt_vec;
    logic        promote_if;
    logic        prot_wr;
    logic        we_sel;
    logic        rd_start;

    // Requests are masked during reset so no grant or strobe can escape.
    always_comb begin
        state_d         = state_q;
        cpu_hold        = 1'b1;
        req_vec         = '0;
        req_vec[REQ_LD] = ld_req & ~rst;
        if (state_q == BOOT) begin
            if (ld_done) begin
                state_d = RUN;
            end
        end else begin
            cpu_hold        = rst;
            req_vec[REQ_D]  = d_req & ~rst;
            req_vec[REQ_IF] = if_req & ~rst;
        end
    end

    assign promote_if = (starve_q == STARVE_LIM) && if_req;

    mem_arb_prio u_prio (
        .req        (req_vec),
        .promote_if (promote_if),
        .gnt        (gnt_vec)
    );

    // Data grants only happen in RUN, so this is already a RUN-only condition.
    assign prot_wr = gnt_vec[REQ_D] & d_we & (d_addr <= PROT_TOP);

    always_comb begin
        mem_addr   = ld_addr;
        mem_wdata  = ld_wdata;
        we_sel     = ld_we;
        rd_owner_d = 2'(REQ_LD);
        if (gnt_vec[REQ_D]) begin
            mem_addr   = d_addr;
            mem_wdata  = d_wdata;
            we_sel     = d_we;
            rd_owner_d = 2'(REQ_D);
        end else if (gnt_vec[REQ_IF]) begin
            mem_addr   = if_addr;
            mem_wdata  = '0;
            we_sel     = 1'b0;
            rd_owner_d = 2'(REQ_IF);
        end
    end

    assign mem_en   = (|gnt_vec) & ~prot_wr;
    assign mem_we   = mem_en & we_sel;
    assign rd_start = mem_en & ~we_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            starve_q   <= '0;
            prot_err_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 2'(REQ_LD);
        end else begin
            state_q <= state_d;
            if (gnt_vec[REQ_IF]) begin
                starve_q <= '0;
            end else if (if_req && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + 4'd1;
            end
            if (prot_wr) begin
                prot_err_q <= 1'b1;
            end
            rd_pend_q <= rd_start;
            if (rd_start) begin
                rd_owner_q <= rd_owner_d;
            end
        end
    end

    assign if_gnt    = gnt_vec[REQ_IF];
    assign d_gnt     = gnt_vec[REQ_D];
    assign ld_gnt    = gnt_vec[REQ_LD];
    assign prot_err  = prot_err_q;

    // A read in flight when reset arrives is dropped immediately.
    assign if_rvalid = rd_pend_q & ~rst & (rd_owner_q == 2'(REQ_IF));
    assign d_rvalid  = rd_pend_q & ~rst & (rd_owner_q == 2'(REQ_D));
    assign ld_rvalid = rd_pend_q & ~rst & (rd_owner_q == 2'(REQ_LD));

    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1024 x 32 synchronous-read memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [9:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        ld_req, ld_we, ld_done, ld_gnt, ld_rvalid;
    logic [9:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic        cpu_hold, prot_err;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_done   (ld_done),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .cpu_hold  (cpu_hold),
        .prot_err  (prot_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_run++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        if_req = 0; d_req = 0; d_we = 0; ld_req = 0; ld_we = 0; ld_done = 0;
    endtask

    initial begin
        rst = 1; idle_all();
        if_addr = '0; d_addr = '0; d_wdata = '0; ld_addr = '0; ld_wdata = '0;

        // Reset: requests present but nothing may be granted.
        tick(); tick();
        ld_req = 1; if_req = 1;
        settle();
        chk("rst_ld_gnt",   32'(ld_gnt),    32'd0);
        chk("rst_if_gnt",   32'(if_gnt),    32'd0);
        chk("rst_mem_en",   32'(mem_en),    32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold),  32'd1);
        chk("rst_prot_err", 32'(prot_err),  32'd0);
        chk("rst_rvalid",   32'({if_rvalid, d_rvalid, ld_rvalid}), 32'd0);
        tick();
        rst = 0; idle_all();

        // BOOT: fetch is refused for three cycles.
        if_req = 1; if_addr = 10'd5;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("boot_if_gnt",   32'(if_gnt),   32'd0);
            chk("boot_cpu_hold", 32'(cpu_hold), 32'd1);
            tick();
        end

        // Loader writes program words; last write coincides with ld_done.
        if_req = 0;
        ld_req = 1; ld_we = 1; ld_addr = 10'd5; ld_wdata = 32'hDEADBEEF;
        settle();
        chk("ld_wr_gnt",  32'(ld_gnt),   32'd1);
        chk("ld_wr_we",   32'(mem_we),   32'd1);
        chk("ld_wr_addr", 32'(mem_addr), 32'd5);
        tick();
        ld_addr = 10'd6; ld_wdata = 32'h12345678; ld_done = 1;
        settle();
        chk("ld_done_gnt", 32'(ld_gnt), 32'd1);
        chk("ld_done_en",  32'(mem_en), 32'd1);
        tick();
        chk("ld_no_rvalid", 32'(ld_rvalid), 32'd0);
        idle_all();

        // RUN: fetch addr 5 granted at once, data next cycle.
        if_req = 1; if_addr = 10'd5;
        settle();
        chk("run_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("run_if_gnt",   32'(if_gnt),   32'd1);
        chk("run_if_we",    32'(mem_we),   32'd0);
        chk("run_if_addr",  32'(mem_addr), 32'd5);
        tick();
        chk("run_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("run_if_rdata",  if_rdata,       32'hDEADBEEF);
        chk("run_d_rvalid",  32'(d_rvalid),  32'd0);

        // Starvation: loads win four cycles, fetch is promoted on the fifth.
        d_req = 1; d_we = 0; d_addr = 10'd6;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk("starve_d_gnt",  32'(d_gnt),  (c != 4) ? 32'd1 : 32'd0);
            chk("starve_if_gnt", 32'(if_gnt), (c == 4) ? 32'd1 : 32'd0);
            tick();
            chk("starve_d_rvalid",  32'(d_rvalid),  (c != 4) ? 32'd1 : 32'd0);
            chk("starve_if_rvalid", 32'(if_rvalid), (c == 4) ? 32'd1 : 32'd0);
            chk("starve_rdata", (c == 4) ? if_rdata : d_rdata,
                (c == 4) ? 32'hDEADBEEF : 32'h12345678);
        end
        idle_all();

        // Protected store: accepted but suppressed, error sticks.
        d_req = 1; d_we = 1; d_addr = 10'd100; d_wdata = 32'd7;
        settle();
        chk("prot_d_gnt",  32'(d_gnt),  32'd1);
        chk("prot_mem_en", 32'(mem_en), 32'd0);
        chk("prot_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("prot_err_set",  32'(prot_err), 32'd1);
        chk("prot_d_rvalid", 32'(d_rvalid), 32'd0);

        d_addr = 10'd255; d_wdata = 32'd9;
        settle();
        chk("prot255_en", 32'(mem_en), 32'd0);
        tick();
        d_addr = 10'd256; d_wdata = 32'd11;
        settle();
        chk("open256_we", 32'(mem_we), 32'd1);
        tick();
        d_addr = 10'd300; d_wdata = 32'h00000ABC;
        settle();
        chk("open300_gnt",   32'(d_gnt),     32'd1);
        chk("open300_we",    32'(mem_we),    32'd1);
        chk("open300_addr",  32'(mem_addr),  32'd300);
        chk("open300_wdata", mem_wdata,      32'h00000ABC);
        tick();
        chk("prot_err_sticky", 32'(prot_err), 32'd1);

        // Loader writes are never protected, even in RUN.
        idle_all();
        ld_req = 1; ld_we = 1; ld_addr = 10'd100; ld_wdata = 32'h22222222;
        settle();
        chk("ld_run_we", 32'(mem_we), 32'd1);
        tick();
        idle_all();
        d_req = 1; d_we = 0; d_addr = 10'd100;
        settle();
        chk("rd100_gnt", 32'(d_gnt), 32'd1);
        tick();
        chk("rd100_rdata", d_rdata, 32'h22222222);
        idle_all();

        // Three-way contention: loader first, then data.
        ld_req = 1; ld_we = 0; ld_addr = 10'd5;
        d_req = 1; d_we = 0; d_addr = 10'd300;
        if_req = 1; if_addr = 10'd6;
        settle();
        chk("all3_ld_gnt", 32'(ld_gnt), 32'd1);
        chk("all3_d_gnt",  32'(d_gnt),  32'd0);
        chk("all3_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        chk("all3_ld_rvalid", 32'(ld_rvalid), 32'd1);
        chk("all3_ld_rdata",  ld_rdata,       32'hDEADBEEF);
        ld_req = 0;
        settle();
        chk("all3_next_d_gnt",  32'(d_gnt),  32'd1);
        chk("all3_next_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        chk("all3_d_rdata", d_rdata, 32'h00000ABC);
        idle_all();

        // ld_done in RUN has no effect.
        ld_done = 1;
        tick();
        ld_done = 0;
        settle();
        chk("run_done_ignored", 32'(cpu_hold), 32'd0);

        // Read in flight when reset arrives is cancelled.
        d_req = 1; d_we = 0; d_addr = 10'd6;
        settle();
        chk("flight_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        rst = 1; idle_all();
        settle();
        chk("flight_rst_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        chk("after_rst_rvalid",   32'(d_rvalid), 32'd0);
        chk("after_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("after_rst_prot_err", 32'(prot_err), 32'd0);
        rst = 0;
        if_req = 1; if_addr = 10'd5;
        settle();
        chk("after_rst_boot_if", 32'(if_gnt), 32'd0);
        tick();
        idle_all();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-clock arbiter and boot sequencer for the shared 1024 x 32 unified instruction/data memory of the MIPS32 pipeline. It shares one synchronous-read memory port between three requesters: the instruction-fetch stage, the MEM-stage load/store path, and an external program loader/debug port. It holds the CPU in a BOOT phase until the loader has written the program. In RUN it applies fixed priority with fetch anti-starvation and enforces write protection on the program region.

## Interface
- AW, 10, memory word-address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is promoted above data (1..15)
- PROT_TOP, 10'd255, highest protected word address; data-path writes at or below it are blocked in RUN
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  load data
- ld_req  in  1  loader/debug request
- ld_we  in  1  loader write enable
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_done  in  1  one-cycle pulse: program load complete
- ld_gnt  out  1  loader request accepted
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DW  loader read data
- cpu_hold  out  1  1 = pipeline must stall (BOOT)
- prot_err  out  1  sticky: blocked protected write seen
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read strobe

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- BOOT: only the loader is served. if_gnt and d_gnt are 0 and cpu_hold is 1. ld_done moves the state to RUN on the next cycle. ld_req in the same cycle as ld_done is still served.
- RUN: cpu_hold is 0.
- Priority in RUN is loader > data > fetch.
- When starve_cnt == STARVE_MAX and if_req is high, priority becomes loader > fetch > data for that cycle. starve_cnt clears on any if_gnt.
- starve_cnt increments each cycle that if_req=1 and if_gnt=0. It saturates at STARVE_MAX and holds its value when if_req=0.
- Exactly one gnt per cycle at most. A gnt drives mem_en=1 with the winner's address, we and wdata.
- A protected write has d_we=1 and d_addr <= PROT_TOP in RUN. For such a write:
  - d_gnt=1, so the requester is not stalled, but mem_en=0 and mem_we=0.
  - prot_err sets and stays set until rst.
- Loader writes are never protected.
- Reads: the winner's rvalid pulses one cycle after gnt, with rdata = mem_rdata. Writes produce no rvalid.
- The rdata outputs all carry mem_rdata and are meaningful only while their rvalid is high.
- A denied requester must hold its req and payload stable until it is granted.
- ld_done in RUN is ignored.
- There is no return path from RUN to BOOT except rst.

## Timing
- Grant logic is combinational from req and registered state. Zero-cycle accept.
- Read latency is 1 cycle from gnt to rvalid.
- Back-to-back grants are permitted every cycle, to the same or different requesters.
- Reset values: state=BOOT, cpu_hold=1, starve_cnt=0, prot_err=0, all rvalid=0.
- All gnt outputs and mem_en are 0 while rst=1.
- rst asserted while a read is in flight: the pending rvalid is cancelled, i.e. 0 in the cycle after rst.

## Structure
- Shared package mips32_mem_pkg holds:
  - AW and DW defaults
  - state enum {BOOT, RUN}
  - requester index constants REQ_LD=0, REQ_D=1, REQ_IF=2
- One sub-module, mem_arb_prio: purely combinational 3-way priority select. Inputs are the req vector and a promote_if flag; output is a one-hot grant. Instantiated once.
- The top level holds the state register, the starvation counter, protection logic, the rvalid pipeline register and the owner-tag register.

## Test plan
- Reset, then if_req=1 for 3 cycles in BOOT -> if_gnt=0 and cpu_hold=1 throughout.
- Loader writes 0xDEADBEEF to addr 5 and pulses ld_done. Then if_req with if_addr=5 -> if_gnt same cycle, and next cycle if_rvalid=1 with if_rdata=0xDEADBEEF.
- In RUN, d_req and if_req held high, loads only, STARVE_MAX=4 -> d_gnt for 4 cycles, if_gnt on the 5th, then d_gnt resumes.
- In RUN, store d_addr=100, d_wdata=7 -> d_gnt=1, mem_we=0, prot_err=1. A later store to addr 300 -> mem_we=1 and prot_err stays 1.
- ld_req, d_req and if_req all asserted in RUN -> ld_gnt only. Next cycle with ld_req dropped -> d_gnt.
- Read granted, rst asserted the next cycle -> rvalid=0, state=BOOT, cpu_hold=1, prot_err=0.
